// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the two-requester register file controller.
package regfile_ctrl_pkg;

  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 16;
  localparam int RF_RD_1      = 0;
  localparam int RF_RD_2      = 1;
  localparam int RF_WR        = 2;
  localparam int DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    DRAIN = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    WAIT1 = 3'd3,
    WAIT2 = 3'd4,
    RESP  = 3'd5
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Register file valid code: both read ports for a read, write port alone for a write.
  function automatic logic [2:0] rf_op_code(input logic we);
    logic [2:0] code;
    code = 3'b000;
    if (we) begin
      code[RF_WR] = 1'b1;
    end else begin
      code[RF_RD_1] = 1'b1;
      code[RF_RD_2] = 1'b1;
    end
    return code;
  endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Requester-side bundle: request handshake plus registered response, for both requesters.
interface regfile_ctrl_if;
  import regfile_ctrl_pkg::*;

  logic              r0_req_valid;
  logic              r0_req_ready;
  logic              r0_req_we;
  logic [ADDR_W-1:0] r0_addr_a;
  logic [ADDR_W-1:0] r0_addr_b;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_rsp_valid;
  logic [DATA_W-1:0] r0_rsp_a;
  logic [DATA_W-1:0] r0_rsp_b;

  logic              r1_req_valid;
  logic              r1_req_ready;
  logic              r1_req_we;
  logic [ADDR_W-1:0] r1_addr_a;
  logic [ADDR_W-1:0] r1_addr_b;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_rsp_valid;
  logic [DATA_W-1:0] r1_rsp_a;
  logic [DATA_W-1:0] r1_rsp_b;

  modport master (
    output r0_req_valid, r0_req_we, r0_addr_a, r0_addr_b, r0_wdata,
    input  r0_req_ready, r0_rsp_valid, r0_rsp_a, r0_rsp_b,
    output r1_req_valid, r1_req_we, r1_addr_a, r1_addr_b, r1_wdata,
    input  r1_req_ready, r1_rsp_valid, r1_rsp_a, r1_rsp_b
  );

  modport slave (
    input  r0_req_valid, r0_req_we, r0_addr_a, r0_addr_b, r0_wdata,
    output r0_req_ready, r0_rsp_valid, r0_rsp_a, r0_rsp_b,
    input  r1_req_valid, r1_req_we, r1_addr_a, r1_addr_b, r1_wdata,
    output r1_req_ready, r1_rsp_valid, r1_rsp_a, r1_rsp_b
  );

endinterface

// File: rtl/regfile_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // 1 when requester 1 was granted last, so requester 0 wins the first tie.
  logic last_p0;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_p0 ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_p0 <= 1'b1;
    end else if (update) begin
      last_p0 <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Round-robin front end for a 32x16, 2-cycle-latency register file; one operation in flight.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  regfile_ctrl_if.slave     bus,
  output logic [2:0]        rf_valid,
  output logic [ADDR_W-1:0] rf_read_addr_1,
  output logic [ADDR_W-1:0] rf_read_addr_2,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_1,
  input  logic [DATA_W-1:0] rf_read_2
);

  state_t            state, state_nxt;
  logic [1:0]        drain_cnt;
  logic [1:0]        req_vld;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              accept;
  req_t              req0, req1, req_sel;

  logic              sel_id_p0;
  logic              we_p0;

  logic [1:0]        rsp_vld_p1;
  logic [DATA_W-1:0] rsp_a_p1 [2];
  logic [DATA_W-1:0] rsp_b_p1 [2];

  assign req_vld = {bus.r1_req_valid, bus.r0_req_valid};
  assign req0    = '{we: bus.r0_req_we, addr_a: bus.r0_addr_a,
                     addr_b: bus.r0_addr_b, wdata: bus.r0_wdata};
  assign req1    = '{we: bus.r1_req_we, addr_a: bus.r1_addr_a,
                     addr_b: bus.r1_addr_b, wdata: bus.r1_wdata};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vld),
    .update (accept),
    .grant  (grant)
  );

  assign ready   = (state == IDLE) ? grant : 2'b00;
  assign accept  = |(req_vld & ready);
  assign req_sel = ready[1] ? req1 : req0;

  assign bus.r0_req_ready = ready[0];
  assign bus.r1_req_ready = ready[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DRAIN;
    end else begin
      state <= state_nxt;
    end
  end

  // Reset holds the count at its top so DRAIN always covers a full register file latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= 2'(DRAIN_CYCLES - 1);
    end else if (state == DRAIN && drain_cnt != 2'd0) begin
      drain_cnt <= drain_cnt - 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    rf_valid  = 3'b000;
    case (state)
      DRAIN: if (drain_cnt == 2'd0) state_nxt = IDLE;
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        rf_valid  = rf_op_code(we_p0);
        state_nxt = WAIT1;
      end
      WAIT1: state_nxt = WAIT2;
      WAIT2: state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = DRAIN;
    endcase
  end

  // Stage p0: accepted request fields, held stable for the register file until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      sel_id_p0      <= ready[1];
      we_p0          <= req_sel.we;
      rf_read_addr_1 <= req_sel.addr_a;
      rf_read_addr_2 <= req_sel.addr_b;
      rf_write_addr  <= req_sel.addr_a;
      rf_write_data  <= req_sel.wdata;
    end
  end

  // Stage p1: registered response towards the issuing requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_p1 <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        rsp_a_p1[i] <= '0;
        rsp_b_p1[i] <= '0;
      end
    end else begin
      rsp_vld_p1[0] <= (state == RESP) && !sel_id_p0;
      rsp_vld_p1[1] <= (state == RESP) &&  sel_id_p0;
      if (state == RESP && !we_p0) begin
        rsp_a_p1[sel_id_p0] <= rf_read_1;
        rsp_b_p1[sel_id_p0] <= rf_read_2;
      end
    end
  end

  assign bus.r0_rsp_valid = rsp_vld_p1[0];
  assign bus.r1_rsp_valid = rsp_vld_p1[1];
  assign bus.r0_rsp_a     = rsp_a_p1[0];
  assign bus.r0_rsp_b     = rsp_b_p1[0];
  assign bus.r1_rsp_a     = rsp_a_p1[1];
  assign bus.r1_rsp_b     = rsp_b_p1[1];

endmodule
